// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation sequencer.
// Holds the state encodings (which also appear on state_dbg), the default
// timing constants and the mode encodings used on valve selection.
package irrigation_pkg;

    localparam int unsigned DEF_SETTLE_CYCLES  = 4;
    localparam int unsigned DEF_MAX_IRR_CYCLES = 1000;
    localparam int unsigned DEF_CLOSE_DELAY    = 2;
    localparam int unsigned DEF_CNT_W          = 16;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_OPEN  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_CLOSE = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam logic MODE_DRIP = 1'b0;
    localparam logic MODE_SPRK = 1'b1;

    typedef enum logic [2:0] {
        S_INIT  = ST_INIT,
        S_IDLE  = ST_IDLE,
        S_OPEN  = ST_OPEN,
        S_RUN   = ST_RUN,
        S_CLOSE = ST_CLOSE,
        S_FAULT = ST_FAULT
    } state_t;

endpackage

// File: rtl/irrigation_timer.sv
// Loadable saturating down-counter shared by the OPEN, RUN and CLOSE phases.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset (count -> 0)
//   load        - load load_val this cycle (wins over en)
//   load_val    - value to load
//   en          - decrement by one; holds at zero, never wraps
//   zero        - count is zero (decoded from the count register)
module irrigation_timer
    import irrigation_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation control FSM: holds actuators safe while init is high, then
// sequences valve and pump from soil-moisture and tank-level sensors with
// settle, run-timeout and close delays plus fault handling.
// Optional feature macro: IRR_SENSOR_FILTER_EN - when defined, the four
// sensor inputs pass through a 2-FF synchroniser and a 3-sample stability
// filter (5 cycles added latency); otherwise they must already be synchronous.
// Ports:
//   clk, reset                 - rising-edge clock, async active-high reset
//   init                       - power-on init level; forces/holds INIT
//   soil_dry, soil_wet         - moisture below low / above high threshold
//   tank_low, tank_empty       - tank below reserve / tank empty
//   mode_sel                   - 0 drip, 1 sprinkler; latched on IDLE->OPEN
//   fault_ack                  - operator acknowledge
//   valve_drip, valve_sprk     - valve drivers
//   pump_on, alarm             - pump enable, FAULT indicator
//   timeout_flag               - sticky run-timeout indication
//   low_water                  - IDLE with soil dry but tank low
//   state_dbg                  - current state encoding
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_IRR_CYCLES = DEF_MAX_IRR_CYCLES,
    parameter int unsigned CLOSE_DELAY    = DEF_CLOSE_DELAY,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       soil_dry,
    input  logic       soil_wet,
    input  logic       tank_low,
    input  logic       tank_empty,
    input  logic       mode_sel,
    input  logic       fault_ack,
    output logic       valve_drip,
    output logic       valve_sprk,
    output logic       pump_on,
    output logic       alarm,
    output logic       timeout_flag,
    output logic       low_water,
    output logic [2:0] state_dbg
);

    logic soil_dry_s;
    logic soil_wet_s;
    logic tank_low_s;
    logic tank_empty_s;

`ifdef IRR_SENSOR_FILTER_EN
    logic [3:0] raw;
    logic [3:0] filt;

    assign raw = {tank_empty, tank_low, soil_wet, soil_dry};

    // Per-sensor synchroniser followed by a filter that only accepts a new
    // level once the synchronised value has been identical for 3 samples.
    for (genvar i = 0; i < 4; i++) begin : g_filt
        logic [1:0] sync;
        logic [1:0] hist;
        logic       val;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync <= '0;
                hist <= '0;
                val  <= 1'b0;
            end else begin
                sync <= {sync[0], raw[i]};
                hist <= {hist[0], sync[1]};
                if ((sync[1] == hist[0]) && (hist[0] == hist[1])) begin
                    val <= sync[1];
                end
            end
        end

        assign filt[i] = val;
    end

    assign {tank_empty_s, tank_low_s, soil_wet_s, soil_dry_s} = filt;
`else
    assign soil_dry_s   = soil_dry;
    assign soil_wet_s   = soil_wet;
    assign tank_low_s   = tank_low;
    assign tank_empty_s = tank_empty;
`endif

    state_t           state;
    state_t           nxt;
    logic             mode_r;
    logic             mode_nxt;
    logic             tflag_nxt;
    logic             low_nxt;
    logic             act_nxt;
    logic             fault_c;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_zero;

    irrigation_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    assign fault_c = tank_empty_s || (soil_dry_s && soil_wet_s);

    // Next state, counter control and next values of latched mode/timeout.
    // Priority: init > fault > soil_wet > counter expiry > the rest.
    always_comb begin
        nxt          = state;
        mode_nxt     = mode_r;
        tflag_nxt    = timeout_flag;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;

        if (init) begin
            nxt       = S_INIT;
            tflag_nxt = 1'b0;
        end else if (fault_c) begin
            nxt = S_FAULT;
        end else begin
            case (state)
                S_INIT: begin
                    nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (soil_dry_s && !tank_low_s) begin
                        nxt          = S_OPEN;
                        mode_nxt     = mode_sel;
                        tflag_nxt    = 1'b0;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
                S_OPEN: begin
                    if (cnt_zero) begin
                        nxt          = S_RUN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MAX_IRR_CYCLES - 1);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_RUN: begin
                    if (soil_wet_s || cnt_zero) begin
                        nxt          = S_CLOSE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(CLOSE_DELAY - 1);
                        // Ending on expiry rather than moisture is a timeout.
                        if (!soil_wet_s) begin
                            tflag_nxt = 1'b1;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_CLOSE: begin
                    if (cnt_zero) begin
                        nxt = S_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                S_FAULT: begin
                    if (fault_ack) begin
                        nxt = S_IDLE;
                    end
                end
                default: begin
                    nxt = S_INIT;
                end
            endcase
        end

        act_nxt = (nxt == S_OPEN) || (nxt == S_RUN) || (nxt == S_CLOSE);
        low_nxt = (nxt == S_IDLE) && soil_dry_s && tank_low_s;
    end

    // State and outputs registered together, outputs decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            mode_r       <= MODE_DRIP;
            valve_drip   <= 1'b0;
            valve_sprk   <= 1'b0;
            pump_on      <= 1'b0;
            alarm        <= 1'b0;
            timeout_flag <= 1'b0;
            low_water    <= 1'b0;
            state_dbg    <= ST_INIT;
        end else begin
            state        <= nxt;
            mode_r       <= mode_nxt;
            valve_drip   <= act_nxt && (mode_nxt == MODE_DRIP);
            valve_sprk   <= act_nxt && (mode_nxt == MODE_SPRK);
            pump_on      <= (nxt == S_RUN);
            alarm        <= (nxt == S_FAULT);
            timeout_flag <= tflag_nxt;
            low_water    <= low_nxt;
            state_dbg    <= nxt;
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer with SETTLE=4, MAX=20, CLOSE=2.
// A phase/remaining-cycles reference model predicts every output each cycle.
module tb_irrigation_sequencer;

    localparam int SETTLE = 4;
    localparam int MAXC   = 20;
    localparam int CLOSEC = 2;

    localparam logic [2:0] P_INIT  = 3'd0;
    localparam logic [2:0] P_IDLE  = 3'd1;
    localparam logic [2:0] P_OPEN  = 3'd2;
    localparam logic [2:0] P_RUN   = 3'd3;
    localparam logic [2:0] P_CLOSE = 3'd4;
    localparam logic [2:0] P_FAULT = 3'd5;

    logic       clk = 1'b0;
    logic       reset, init, soil_dry, soil_wet, tank_low, tank_empty, mode_sel, fault_ack;
    logic       valve_drip, valve_sprk, pump_on, alarm, timeout_flag, low_water;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus cycles remaining in that phase.
    logic [2:0] m_ph;
    int         m_left;
    logic       m_mode, m_tflag, m_low, m_act;
    logic [8:0] exp_vec, dut_vec;
    logic       inv_ok;

    irrigation_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .MAX_IRR_CYCLES (MAXC),
        .CLOSE_DELAY    (CLOSEC),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .soil_dry     (soil_dry),
        .soil_wet     (soil_wet),
        .tank_low     (tank_low),
        .tank_empty   (tank_empty),
        .mode_sel     (mode_sel),
        .fault_ack    (fault_ack),
        .valve_drip   (valve_drip),
        .valve_sprk   (valve_sprk),
        .pump_on      (pump_on),
        .alarm        (alarm),
        .timeout_flag (timeout_flag),
        .low_water    (low_water),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    assign dut_vec = {valve_drip, valve_sprk, pump_on, alarm, timeout_flag, low_water, state_dbg};
    assign m_act   = (m_ph == P_OPEN) || (m_ph == P_RUN) || (m_ph == P_CLOSE);
    assign exp_vec = {m_act && !m_mode, m_act && m_mode, m_ph == P_RUN, m_ph == P_FAULT,
                      m_tflag, m_low, m_ph};
    assign inv_ok  = !(valve_drip && valve_sprk) && (!pump_on || (valve_drip ^ valve_sprk));

    task automatic model_reset();
        m_ph = P_INIT; m_left = 0; m_mode = 1'b0; m_tflag = 1'b0; m_low = 1'b0;
    endtask

    task automatic model_step();
        logic flt;
        flt = tank_empty || (soil_dry && soil_wet);
        if (init) begin
            m_ph = P_INIT; m_tflag = 1'b0;
        end else if (flt) begin
            m_ph = P_FAULT;
        end else begin
            case (m_ph)
                P_INIT:  m_ph = P_IDLE;
                P_IDLE:  if (soil_dry && !tank_low) begin
                             m_ph = P_OPEN; m_left = SETTLE; m_mode = mode_sel; m_tflag = 1'b0;
                         end
                P_OPEN:  if (m_left == 1) begin m_ph = P_RUN; m_left = MAXC; end
                         else m_left--;
                P_RUN:   if (soil_wet) begin m_ph = P_CLOSE; m_left = CLOSEC; end
                         else if (m_left == 1) begin m_ph = P_CLOSE; m_left = CLOSEC; m_tflag = 1'b1; end
                         else m_left--;
                P_CLOSE: if (m_left == 1) m_ph = P_IDLE; else m_left--;
                P_FAULT: if (fault_ack) m_ph = P_IDLE;
                default: m_ph = P_INIT;
            endcase
        end
        m_low = (m_ph == P_IDLE) && soil_dry && tank_low;
    endtask

    // Advance model and DUT by one edge; sample 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; soil_dry = 0; soil_wet = 0; tank_low = 0;
        tank_empty = 0; mode_sel = 0; fault_ack = 0;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (dut_vec !== 9'b0) begin bad++; $display("FAIL reset_vec got=%b exp=%b", dut_vec, 9'b0); end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec || state_dbg !== P_INIT) begin
                bad++; $display("FAIL init_hold c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
            end
        end
        init = 1'b0;
        tick();
        total++;
        if (dut_vec !== exp_vec || state_dbg !== P_IDLE) begin
            bad++; $display("FAIL init_release got=%b exp=%b", dut_vec, exp_vec);
        end
    endtask

    task automatic test_sprinkler_run();
        int pre = 0, pon = 0, post = 0;
        bit seen = 0, done = 0;
        mode_sel = 1'b1; soil_dry = 1'b1;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec || inv_ok !== 1'b1) begin
                bad++; $display("FAIL sprk_cycle c=%0d got=%b exp=%b inv=%b", c, dut_vec, exp_vec, inv_ok);
            end
            if (state_dbg == P_OPEN) soil_dry = 1'b0;
            if (pump_on) begin seen = 1; pon++; end
            else if (valve_sprk && !seen) pre++;
            else if (valve_sprk && seen) post++;
            if (pon == 10 && !soil_wet) soil_wet = 1'b1;
            if (seen && state_dbg == P_IDLE) done = 1;
        end
        soil_wet = 1'b0;
        total++; if (!done)      begin bad++; $display("FAIL sprk_end got=not_idle exp=idle"); end
        total++; if (pre !== 4)  begin bad++; $display("FAIL sprk_settle got=%0d exp=4", pre); end
        total++; if (pon !== 10) begin bad++; $display("FAIL sprk_pump_len got=%0d exp=10", pon); end
        total++; if (post !== 2) begin bad++; $display("FAIL sprk_close got=%0d exp=2", post); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL sprk_tflag got=%b exp=0", timeout_flag); end
    endtask

    task automatic test_timeout();
        int pon = 0, sprk = 0;
        bit idle_seen = 0, done = 0;
        mode_sel = 1'b0; soil_dry = 1'b1;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec || inv_ok !== 1'b1) begin
                bad++; $display("FAIL tmo_cycle c=%0d got=%b exp=%b inv=%b", c, dut_vec, exp_vec, inv_ok);
            end
            if (pump_on) begin
                pon++;
                if (pon == 7 || pon == 13) mode_sel = ~mode_sel;
            end
            if (valve_sprk) sprk++;
            if (idle_seen && state_dbg == P_OPEN) begin
                total++;
                if (timeout_flag !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", timeout_flag); end
                done = 1;
            end
            if (pon > 0 && state_dbg == P_IDLE && !idle_seen) begin
                idle_seen = 1;
                total++;
                if (timeout_flag !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b exp=1", timeout_flag); end
            end
        end
        total++; if (!done)      begin bad++; $display("FAIL tmo_restart got=none exp=restart"); end
        total++; if (pon !== 20) begin bad++; $display("FAIL tmo_pump_len got=%0d exp=20", pon); end
        total++; if (sprk !== 0) begin bad++; $display("FAIL tmo_mode_change got=%0d exp=0", sprk); end
        soil_dry = 1'b0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL tmo_drain c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
            if (state_dbg == P_IDLE) done = 1;
        end
        total++; if (!done) begin bad++; $display("FAIL tmo_drain_end got=%0d exp=%0d", state_dbg, P_IDLE); end
    endtask

    task automatic test_fault();
        mode_sel = 1'($urandom_range(0, 1)); soil_dry = 1'b1;
        for (int c = 0; c < 20 && state_dbg != P_RUN; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin bad++; $display("FAIL flt_start c=%0d got=%b exp=%b", c, dut_vec, exp_vec); end
            if (state_dbg == P_OPEN) soil_dry = 1'b0;
        end
        total++; if (state_dbg !== P_RUN) begin bad++; $display("FAIL flt_reach_run got=%0d exp=%0d", state_dbg, P_RUN); end
        tank_empty = 1'b1;
        tick();
        total++;
        if ({valve_drip, valve_sprk, pump_on, alarm} !== 4'b0001 || dut_vec !== exp_vec) begin
            bad++; $display("FAIL flt_entry got=%b exp=%b", dut_vec, exp_vec);
        end
        fault_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (state_dbg !== P_FAULT || dut_vec !== exp_vec) begin
                bad++; $display("FAIL flt_ack_ignored c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
            end
        end
        tank_empty = 1'b0;
        tick();
        total++;
        if (state_dbg !== P_IDLE || dut_vec !== exp_vec) begin
            bad++; $display("FAIL flt_recover got=%b exp=%b", dut_vec, exp_vec);
        end
        fault_ack = 1'b0;
    endtask

    task automatic test_corners();
        soil_dry = 1'b1; soil_wet = 1'b1;
        tick();
        total++;
        if (state_dbg !== P_FAULT || dut_vec !== exp_vec) begin
            bad++; $display("FAIL dry_wet_fault got=%b exp=%b", dut_vec, exp_vec);
        end
        soil_dry = 1'b0; soil_wet = 1'b0; fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        total++;
        if (state_dbg !== P_IDLE || dut_vec !== exp_vec) begin
            bad++; $display("FAIL dry_wet_recover got=%b exp=%b", dut_vec, exp_vec);
        end
        tank_low = 1'b1; soil_dry = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({state_dbg, low_water, pump_on} !== {P_IDLE, 2'b10} || dut_vec !== exp_vec) begin
                bad++; $display("FAIL low_water c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
            end
        end
        tank_low = 1'b0; soil_dry = 1'b0;
        tick();
        total++;
        if (dut_vec !== exp_vec) begin bad++; $display("FAIL low_water_clear got=%b exp=%b", dut_vec, exp_vec); end
    endtask

    task automatic test_init_reset();
        soil_dry = 1'b1; mode_sel = 1'b1;
        for (int c = 0; c < 5 && state_dbg != P_OPEN; c++) tick();
        total++; if (state_dbg !== P_OPEN) begin bad++; $display("FAIL ini_reach_open got=%0d exp=%0d", state_dbg, P_OPEN); end
        soil_dry = 1'b0; init = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (dut_vec !== 9'b0 || dut_vec !== exp_vec) begin
                bad++; $display("FAIL ini_mid_open c=%0d got=%b exp=%b", c, dut_vec, exp_vec);
            end
        end
        init = 1'b0;
        tick();
        total++;
        if (state_dbg !== P_IDLE || dut_vec !== exp_vec) begin bad++; $display("FAIL ini_release got=%b exp=%b", dut_vec, exp_vec); end
        soil_dry = 1'b1;
        for (int c = 0; c < 10 && state_dbg != P_RUN; c++) tick();
        total++; if (pump_on !== 1'b1 || inv_ok !== 1'b1) begin bad++; $display("FAIL rst_reach_run got=%b exp=1", pump_on); end
        soil_dry = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (dut_vec !== 9'b0 || dut_vec !== exp_vec) begin bad++; $display("FAIL rst_async got=%b exp=%b", dut_vec, exp_vec); end
        #1;
        reset = 1'b0;
        tick();
        total++;
        if (state_dbg !== P_IDLE || dut_vec !== exp_vec) begin bad++; $display("FAIL rst_release got=%b exp=%b", dut_vec, exp_vec); end
    endtask

    task automatic test_random();
        int hold;
        for (int c = 0; c < 900; c += hold) begin
            hold       = int'($urandom_range(1, 6));
            init       = ($urandom_range(0, 99) < 2);
            soil_dry   = 1'($urandom_range(0, 1));
            soil_wet   = soil_dry ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 3) == 0);
            tank_low   = ($urandom_range(0, 7) == 0);
            tank_empty = ($urandom_range(0, 39) == 0);
            mode_sel   = 1'($urandom_range(0, 1));
            fault_ack  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < hold; k++) begin
                tick();
                total++;
                if (dut_vec !== exp_vec || inv_ok !== 1'b1) begin
                    bad++; $display("FAIL random c=%0d got=%b exp=%b inv=%b", c + k, dut_vec, exp_vec, inv_ok);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sprinkler_run();
        test_timeout();
        test_fault();
        test_corners();
        test_init_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Control FSM for the irrigation system; sits directly downstream of the power-on initialisation one-shot and consumes its init level.
- Holds all actuators safe while init is high.
- Afterwards sequences the valve and pump from soil-moisture and tank-level sensors, with timeout and fault handling.
- Drives the valve/pump driver outputs and the alarm indicator.

Parameters:
- SETTLE_CYCLES, 4: cycles the valve is open before the pump starts (1..2^CNT_W-1).
- MAX_IRR_CYCLES, 1000: maximum cycles pump_on may stay high in one run (1..2^CNT_W-1).
- CLOSE_DELAY, 2: cycles the valve stays open after the pump stops (1..2^CNT_W-1).
- CNT_W, 16: width of the shared down-counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  from the power-on one-shot; while 1, the FSM is forced to and held in INIT.
- soil_dry  in  1  moisture below the low threshold.
- soil_wet  in  1  moisture above the high threshold.
- tank_low  in  1  tank below reserve; blocks new starts.
- tank_empty  in  1  tank empty; fault in every non-INIT state.
- mode_sel  in  1  0 = drip, 1 = sprinkler; sampled on IDLE->OPEN.
- fault_ack  in  1  operator acknowledge.
- valve_drip  out  1  drip valve open.
- valve_sprk  out  1  sprinkler valve open.
- pump_on  out  1  pump enable.
- alarm  out  1  high while in FAULT.
- timeout_flag  out  1  sticky; set when a run ends by timeout, cleared on the next IDLE->OPEN.
- low_water  out  1  high in IDLE when soil_dry=1 and tank_low=1.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to INIT; counter 0.
  - valve_drip, valve_sprk, pump_on, alarm, timeout_flag, low_water all 0; state_dbg = INIT.
- All outputs are registered and decoded from the next state, so outputs track state in the same cycle as the state update.
- States (state_dbg encoding): INIT=0, IDLE=1, OPEN=2, RUN=3, CLOSE=4, FAULT=5.
- Priority each cycle: init > fault condition > soil_wet > counter expiry > other transitions.
  - Fault condition = tank_empty OR (soil_dry AND soil_wet).
- INIT:
  - Stay while init=1.
  - When init=0: go to FAULT if the fault condition holds, else IDLE.
- IDLE:
  - If soil_dry=1, tank_low=0 and no fault: go to OPEN.
    - Latch mode_sel into mode_r.
    - Load counter with SETTLE_CYCLES-1.
    - Clear timeout_flag.
  - soil_dry=1 with tank_low=1: stay in IDLE, low_water=1.
- OPEN:
  - Valve selected by mode_r = 1; pump 0.
  - Counter decrements; at 0, go to RUN and load MAX_IRR_CYCLES-1.
  - The valve is high exactly SETTLE_CYCLES cycles before pump_on rises.
- RUN:
  - Valve and pump = 1.
  - soil_wet=1: go to CLOSE (load CLOSE_DELAY-1).
  - Counter at 0 with soil_wet=0: go to CLOSE and set timeout_flag.
  - pump_on is never high more than MAX_IRR_CYCLES consecutive cycles.
- CLOSE:
  - pump 0, valve still 1.
  - At counter 0: go to IDLE, valves 0.
  - soil_dry during CLOSE is ignored; a restart needs one IDLE cycle.
- FAULT:
  - All actuators 0, alarm=1.
  - Go to IDLE only when fault_ack=1 and the fault condition is clear in the same cycle.
  - fault_ack while the fault persists is ignored.
- Any state except INIT: fault condition moves to FAULT next cycle; pump and valves drop in that same update (no CLOSE delay).
- init=1 in any state: go to INIT next cycle, all outputs cleared.
  - timeout_flag is also cleared.
- Invariants:
  - valve_drip and valve_sprk are never both 1.
  - pump_on=1 implies exactly one valve is 1.
  - mode_sel changes during a run have no effect.
- Counter:
  - Single CNT_W-bit down-counter, shared by OPEN, RUN and CLOSE.
  - Loaded on state entry; saturates at 0 and never wraps.

Optional Feature:
- IRR_SENSOR_FILTER_EN defined:
  - soil_dry, soil_wet, tank_low and tank_empty each pass through a 2-FF synchroniser plus a 3-cycle stability filter. A filtered value changes only after the raw input is stable for 3 consecutive cycles.
  - Adds 5 cycles of sensor-to-decision latency.
  - Filter registers reset to 0.
- Undefined:
  - Inputs are used directly; they must already be synchronous to clk.

Decomposition:
- Shared package/include irrigation_pkg:
  - State encodings (3-bit localparams), default timing constants, MODE_DRIP=0 and MODE_SPRK=1.
- Sub-module irrigation_timer: loadable saturating down-counter.
  - Ports: clk, reset, load, load_val[CNT_W], en, zero.
- The sensor filter, when enabled, is a generate-replicated block inside the top.

Test Plan:
Timing for all scenarios: SETTLE=4, MAX=20, CLOSE=2.
1. Reset, init=1 for 3 cycles, then 0 -> state INIT for 3 cycles, then IDLE; all actuators 0 throughout.
2. soil_dry=1, mode_sel=1, tank ok; soil_wet=1 after 10 RUN cycles -> valve_sprk high 4 cycles before pump_on; pump_on high 10 cycles; valve falls 2 cycles after pump; timeout_flag=0.
3. soil_dry held, soil_wet never -> pump_on high exactly 20 cycles, timeout_flag=1 until next start; mode_sel toggled mid-run leaves valve_drip unchanged.
4. tank_empty=1 in RUN -> next cycle pump_on=0, valves 0, alarm=1. fault_ack while empty -> stays FAULT; tank_empty=0 plus fault_ack -> IDLE.
5. Corner cases, one per sub-case:
   - soil_dry and soil_wet both 1 in IDLE -> FAULT.
   - tank_low=1 with soil_dry -> stays IDLE, low_water=1, pump never on.
6. init=1 reasserted mid-OPEN, and separately async reset mid-RUN -> INIT with all outputs 0 (immediately for reset, next cycle for init); the bench checks the valve/pump invariants every cycle.
